// File: rtl/cistern_pump_if.sv
// Sensor, request and status bundle between the cistern pump controller and its environment.
interface cistern_pump_if;
  logic [7:0] floater;
  logic       manual_req;
  logic       fault_clr;
  logic       pump_on;
  logic [3:0] level;
  logic       level_valid;
  logic       fault;
  logic [1:0] fault_code;
  logic [3:0] disp_code;

  modport master (
    output floater, manual_req, fault_clr,
    input  pump_on, level, level_valid, fault, fault_code, disp_code
  );

  modport slave (
    input  floater, manual_req, fault_clr,
    output pump_on, level, level_valid, fault, fault_code, disp_code
  );
endinterface

// File: rtl/cistern_pump_ctrl.sv
// Cistern pump controller: floater debounce, thermometer validation/encoding,
// and a hysteresis fill FSM with sensor and dry-run fault detection.
module cistern_pump_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int LOW_LEVEL       = 2,
  parameter int HIGH_LEVEL      = 8,
  parameter int MAX_FILL_CYCLES = 1024
) (
  input  logic           clk,
  input  logic           rst,
  cistern_pump_if.slave  bus
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int FW = $clog2(MAX_FILL_CYCLES);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 2);
  localparam logic [FW-1:0] FILL_LAST = FW'(MAX_FILL_CYCLES - 1);
  localparam logic [3:0]    LOW_L     = 4'(LOW_LEVEL);
  localparam logic [3:0]    HIGH_L    = 4'(HIGH_LEVEL);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_FAULT = 2'd2
  } state_e;

  // A thermometer code has no zero below a one, so c & (c+1) is zero.
  function automatic logic code_legal(input logic [7:0] c);
    logic [8:0] p;
    p = {1'b0, c} + 9'd1;
    return (c & p[7:0]) == 8'h00;
  endfunction

  function automatic logic [3:0] code_level(input logic [7:0] c);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, c[i]};
    return n;
  endfunction

  logic [7:0]    cand_q;
  logic [DW-1:0] deb_cnt_q;
  logic [7:0]    committed_q;
  logic [3:0]    level_q;
  logic          level_valid_q;

  // Debounce and commit stage
  always_ff @(posedge clk) begin
    if (rst) begin
      cand_q        <= 8'h00;
      deb_cnt_q     <= '0;
      committed_q   <= 8'h00;
      level_q       <= 4'd0;
      level_valid_q <= 1'b0;
    end else if (bus.floater != cand_q) begin
      cand_q    <= bus.floater;
      deb_cnt_q <= '0;
    end else if (deb_cnt_q == DEB_LAST) begin
      committed_q   <= cand_q;
      level_q       <= code_legal(cand_q) ? code_level(cand_q) : 4'd0;
      level_valid_q <= code_legal(cand_q);
    end else begin
      deb_cnt_q <= deb_cnt_q + DW'(1);
    end
  end

  state_e        state_q, state_d;
  logic [FW-1:0] fill_cnt_q, fill_cnt_d;
  logic [1:0]    fault_code_q, fault_code_d;
  logic [3:0]    prev_level_q;
  logic          pump_on_q, fault_q;
  logic [3:0]    disp_code_q;
  logic          code_ok, level_up;

  assign code_ok  = code_legal(committed_q);
  assign level_up = level_q > prev_level_q;

  // Fill state machine stage
  always_comb begin
    state_d      = state_q;
    fill_cnt_d   = fill_cnt_q;
    fault_code_d = fault_code_q;
    case (state_q)
      ST_IDLE: begin
        if (!code_ok) begin
          state_d      = ST_FAULT;
          fault_code_d = 2'b01;
        end else if (level_valid_q &&
                     (level_q <= LOW_L || (bus.manual_req && level_q < HIGH_L))) begin
          state_d    = ST_FILL;
          fill_cnt_d = '0;
        end
      end
      ST_FILL: begin
        if (!code_ok) begin
          state_d      = ST_FAULT;
          fault_code_d = 2'b01;
        end else if (level_q >= HIGH_L) begin
          state_d = ST_IDLE;
        end else if (fill_cnt_q == FILL_LAST && !level_up) begin
          state_d      = ST_FAULT;
          fault_code_d = 2'b10;
        end else if (level_up) begin
          fill_cnt_d = '0;
        end else begin
          fill_cnt_d = fill_cnt_q + FW'(1);
        end
      end
      ST_FAULT: begin
        if (bus.fault_clr && level_valid_q && code_ok) begin
          state_d      = ST_IDLE;
          fault_code_d = 2'b00;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      fill_cnt_q   <= '0;
      fault_code_q <= 2'b00;
      prev_level_q <= 4'd0;
      pump_on_q    <= 1'b0;
      fault_q      <= 1'b0;
      disp_code_q  <= 4'd0;
    end else begin
      state_q      <= state_d;
      fill_cnt_q   <= fill_cnt_d;
      fault_code_q <= fault_code_d;
      prev_level_q <= level_q;
      pump_on_q    <= (state_d == ST_FILL);
      fault_q      <= (state_d == ST_FAULT);
      disp_code_q  <= (state_d == ST_FAULT) ? 4'hE : level_q;
    end
  end

  assign bus.pump_on     = pump_on_q;
  assign bus.level       = level_q;
  assign bus.level_valid = level_valid_q;
  assign bus.fault       = fault_q;
  assign bus.fault_code  = fault_code_q;
  assign bus.disp_code   = disp_code_q;

endmodule

// File: tb/tb_cistern_pump_ctrl.sv
// Bench for cistern_pump_ctrl: directed scenarios then random floater traffic,
// all outputs compared every edge against a sample-history reference model.
module tb_cistern_pump_ctrl;
  localparam int DC   = 4;
  localparam int LOW  = 2;
  localparam int HIGH = 8;
  localparam int MAXF = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cistern_pump_if bus();

  cistern_pump_ctrl #(
    .DEBOUNCE_CYCLES(DC),
    .LOW_LEVEL(LOW),
    .HIGH_LEVEL(HIGH),
    .MAX_FILL_CYCLES(MAXF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] legal_tab [9] = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F,
                                8'h1F, 8'h3F, 8'h7F, 8'hFF};

  // Reference state: run length of identical samples, mode 0/1/2 = idle/fill/fault
  logic [7:0] m_last, m_comm;
  int m_run, m_lvl, m_vld, m_mode, m_code, m_prev, m_prog, cyc;
  int m_pump, m_fault, m_disp;

  function automatic int lvl_of(input logic [7:0] c);
    for (int i = 0; i < 9; i++) if (c == legal_tab[i]) return i;
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_edge();
    int ok, inc, l;
    cyc++;
    if (rst) begin
      m_last = 8'h00; m_run = 1; m_comm = 8'h00; m_lvl = 0; m_vld = 0;
      m_mode = 0; m_code = 0; m_prev = 0; m_prog = cyc;
      m_pump = 0; m_fault = 0; m_disp = 0;
      return;
    end
    ok  = (lvl_of(m_comm) >= 0);
    inc = (m_lvl > m_prev);
    case (m_mode)
      0: begin
        if (!ok) begin m_mode = 2; m_code = 1; end
        else if (m_vld != 0 && (m_lvl <= LOW || (bus.manual_req && m_lvl < HIGH))) begin
          m_mode = 1; m_prog = cyc;
        end
      end
      1: begin
        if (!ok) begin m_mode = 2; m_code = 1; end
        else if (m_lvl >= HIGH) m_mode = 0;
        else if (inc == 0 && cyc - m_prog == MAXF) begin m_mode = 2; m_code = 2; end
        else if (inc != 0) m_prog = cyc;
      end
      default: begin
        if (bus.fault_clr && m_vld != 0 && ok) begin m_mode = 0; m_code = 0; end
      end
    endcase
    m_pump  = (m_mode == 1);
    m_fault = (m_mode == 2);
    m_disp  = (m_mode == 2) ? 14 : m_lvl;
    m_prev  = m_lvl;
    if (bus.floater == m_last) m_run = (m_run < DC) ? m_run + 1 : DC;
    else begin m_last = bus.floater; m_run = 1; end
    if (m_run >= DC) begin
      m_comm = m_last;
      l = lvl_of(m_last);
      m_vld = (l >= 0);
      m_lvl = (l >= 0) ? l : 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("pump_on",     32'(bus.pump_on),     32'(m_pump));
    chk("level",       32'(bus.level),       32'(m_lvl));
    chk("level_valid", 32'(bus.level_valid), 32'(m_vld));
    chk("fault",       32'(bus.fault),       32'(m_fault));
    chk("fault_code",  32'(bus.fault_code),  32'(m_code));
    chk("disp_code",   32'(bus.disp_code),   32'(m_disp));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    logic [7:0] v;
    int hold;
    cyc = 0;
    rst = 1'b1;
    bus.floater = 8'h00;
    bus.manual_req = 1'b0;
    bus.fault_clr = 1'b0;
    ticks(2);
    chk("reset_pump", 32'(bus.pump_on), 0);
    chk("reset_valid", 32'(bus.level_valid), 0);
    chk("reset_disp", 32'(bus.disp_code), 0);
    rst = 1'b0;

    // Scenario 1: auto fill from level 2 up to 8
    bus.floater = 8'h03;
    ticks(4);
    chk("s1_level2", 32'(bus.level), 2);
    chk("s1_valid", 32'(bus.level_valid), 1);
    chk("s1_pump_before", 32'(bus.pump_on), 0);
    tick();
    chk("s1_pump_start", 32'(bus.pump_on), 1);
    foreach (legal_tab[i]) begin
      if (i >= 3) begin
        bus.floater = legal_tab[i];
        ticks(4);
        chk("s1_level_track", 32'(bus.level), 32'(i));
        ticks(6);
      end
    end
    chk("s1_pump_stop", 32'(bus.pump_on), 0);
    chk("s1_disp8", 32'(bus.disp_code), 8);

    // Scenario 2: short glitch ignored, then manual fill
    bus.floater = 8'h1F;
    ticks(10);
    bus.floater = 8'h3F;
    ticks(3);
    bus.floater = 8'h1F;
    ticks(10);
    chk("s2_glitch_level", 32'(bus.level), 5);
    chk("s2_idle_pump", 32'(bus.pump_on), 0);
    bus.manual_req = 1'b1;
    tick();
    chk("s2_manual_pump", 32'(bus.pump_on), 1);
    bus.manual_req = 1'b0;
    bus.floater = 8'hFF;
    ticks(10);

    // Scenario 3: dry-run exactly MAXF edges after fill entry
    bus.floater = 8'h03;
    ticks(5);
    chk("s3_fill_entry", 32'(bus.pump_on), 1);
    ticks(MAXF - 1);
    chk("s3_no_fault_yet", 32'(bus.fault), 0);
    tick();
    chk("s3_fault", 32'(bus.fault), 1);
    chk("s3_code", 32'(bus.fault_code), 2);
    chk("s3_pump_off", 32'(bus.pump_on), 0);
    chk("s3_disp", 32'(bus.disp_code), 14);
    bus.fault_clr = 1'b1;
    tick();
    bus.fault_clr = 1'b0;
    chk("s3_cleared", 32'(bus.fault_code), 0);
    bus.floater = 8'hFF;
    ticks(10);

    // Scenario 4: sensor fault, clear refused while invalid
    bus.floater = 8'h05;
    ticks(4);
    chk("s4_invalid", 32'(bus.level_valid), 0);
    chk("s4_level0", 32'(bus.level), 0);
    tick();
    chk("s4_fault", 32'(bus.fault), 1);
    chk("s4_code", 32'(bus.fault_code), 1);
    bus.fault_clr = 1'b1;
    tick();
    bus.fault_clr = 1'b0;
    chk("s4_clr_refused", 32'(bus.fault), 1);
    bus.floater = 8'h0F;
    ticks(4);
    bus.fault_clr = 1'b1;
    tick();
    bus.fault_clr = 1'b0;
    chk("s4_clr_ok", 32'(bus.fault), 0);
    chk("s4_code_clear", 32'(bus.fault_code), 0);
    ticks(3);

    // Scenario 5: reset mid-fill
    bus.floater = 8'h01;
    ticks(5);
    chk("s5_filling", 32'(bus.pump_on), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("s5_rst_pump", 32'(bus.pump_on), 0);
    chk("s5_rst_valid", 32'(bus.level_valid), 0);
    ticks(4);
    chk("s5_not_yet", 32'(bus.pump_on), 0);
    tick();
    chk("s5_restart", 32'(bus.pump_on), 1);

    // Scenario 6: step lands on the last counter edge; invalid code beats level
    ticks(MAXF - 5);
    bus.floater = 8'h03;
    ticks(4);
    tick();
    chk("s6_no_fault", 32'(bus.fault), 0);
    chk("s6_still_fill", 32'(bus.pump_on), 1);
    bus.floater = 8'hFE;
    ticks(5);
    chk("s6_sensor_fault", 32'(bus.fault), 1);
    chk("s6_sensor_code", 32'(bus.fault_code), 1);

    // Random traffic
    for (int seg = 0; seg < 250; seg++) begin
      if ($urandom_range(0, 9) < 7) v = legal_tab[$urandom_range(0, 8)];
      else v = 8'($urandom);
      bus.floater    = v;
      bus.manual_req = ($urandom_range(0, 3) == 0);
      bus.fault_clr  = ($urandom_range(0, 2) == 0);
      rst            = ($urandom_range(0, 39) == 0);
      hold = ($urandom_range(0, 7) == 0) ? $urandom_range(30, 45) : $urandom_range(1, 12);
      for (int k = 0; k < hold; k++) begin
        tick();
        bus.fault_clr = 1'b0;
        rst = 1'b0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/cistern_pump_ctrl.md
Name: cistern_pump_ctrl

Overview:
Pump controller for the cistern level sensor string. It debounces the 8-bit floater thermometer input, validates and encodes it to a 0..8 level, and runs a fill state machine with hysteresis. The state machine drives the pump and detects dry-run and sensor faults. Its display code output feeds the existing hex-to-seven-segment decoder, with 4'hE shown on error.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive identical samples required before a floater value is committed (>=2)
LOW_LEVEL, 2, committed level at or below which an automatic fill starts (0..7)
HIGH_LEVEL, 8, committed level at or above which a fill stops (LOW_LEVEL+1..8)
MAX_FILL_CYCLES, 1024, max cycles in FILL without a level increase before dry-run fault (>=2)

Ports:
clk  in  1  system clock, all logic rising-edge
rst  in  1  synchronous reset, active-high
floater  in  8  raw float switches, bit0 = lowest, asynchronous to clk (bench drives synchronously)
manual_req  in  1  level-sensitive request to start a fill from IDLE
fault_clr  in  1  single-cycle pulse, clears FAULT
pump_on  out  1  pump enable, registered
level  out  4  committed level 0..8 (0 while invalid)
level_valid  out  1  committed pattern is a legal thermometer code
fault  out  1  high in FAULT state
fault_code  out  2  00 none, 01 sensor, 10 dry-run; held until cleared
disp_code  out  4  level when not in FAULT, 4'hE in FAULT

Behaviour:
- Reset is synchronous and active-high, clock clk. At rst: cand=0, deb_cnt=0, committed=8'h00, level_valid=0, level=0, state=IDLE, pump_on=0, fault=0, fault_code=00, fill_cnt=0, disp_code=0. Reset mid-fill drops pump_on on the same edge.
- Debounce, per edge:
  - If floater != cand: cand<=floater, deb_cnt<=0.
  - Else if deb_cnt==DEBOUNCE_CYCLES-2: committed<=cand, and deb_cnt saturates.
  - Else deb_cnt++.
  - Net effect: committed updates on the DEBOUNCE_CYCLES-th consecutive edge sampling the same value. A glitch shorter than that never commits.
  - level_valid goes to 1 only after the first commit following reset.
- Encoding is combinational from committed, registered into level/level_valid on the commit edge.
  - Legal codes: 8'h00, 01, 03, 07, 0F, 1F, 3F, 7F, FF, giving level = number of ones.
  - Any other code: level_valid=0, level=0.
- State machine (state, pump_on, fault, disp_code registered; they act one edge after the commit that triggers them):
  - IDLE: pump_on=0.
    - Go to FAULT(01) if a committed invalid code is present.
    - Else go to FILL if level_valid and (level<=LOW_LEVEL, or manual_req with level<HIGH_LEVEL).
    - Never fill before the first valid commit.
  - FILL: pump_on=1. fill_cnt clears on entry and on every edge where the committed level increases; otherwise it increments. Priorities, highest first:
    - Invalid code: go to FAULT(01).
    - level>=HIGH_LEVEL: go to IDLE.
    - fill_cnt==MAX_FILL_CYCLES-1 with no increase this edge: go to FAULT(10).
    - A level decrease during FILL is ignored (counter keeps running).
  - FAULT: pump_on=0, fault=1, disp_code=4'hE. manual_req is ignored.
    - fault_clr with level_valid=1 and a legal committed code: go to IDLE, fault_code<=00.
    - fault_clr while the code is invalid: no effect, fault_code unchanged.
    - From IDLE, auto-fill is re-evaluated on the following edge.
- The sensor fault (01) overwrites a pending dry-run (10) only on FAULT entry. Once in FAULT, the code is frozen.
- fill_cnt width is clog2(MAX_FILL_CYCLES). It never wraps because the FAULT transition happens first.

Test Plan:
(Bench parameters: DEBOUNCE_CYCLES=4, LOW_LEVEL=2, HIGH_LEVEL=8, MAX_FILL_CYCLES=32.)
1. Reset, then floater=8'h03 held -> level=2, level_valid=1 on the 4th edge; pump_on=1 on the 5th edge. Step floater 07,0F,...,FF with each value held 10 cycles -> level tracks 3..8, pump_on=0 one edge after level=8, disp_code=8.
2. floater=8'h1F stable, pulse floater=8'h3F for 3 cycles, then back -> level stays 5, no state change. Then manual_req=1 -> FILL, pump_on=1.
3. In FILL at level=2, hold floater constant -> fault=1, fault_code=10, pump_on=0, disp_code=E exactly 32 edges after FILL entry.
4. floater=8'h05 held from IDLE -> after 4 edges level_valid=0, level=0. Next edge: fault=1, fault_code=01. fault_clr pulse while still 05 -> remains FAULT. Set floater=8'h0F, wait 4, pulse fault_clr -> IDLE, fault_code=00.
5. In FILL with pump_on=1, assert rst for 1 cycle -> pump_on=0, state IDLE, level_valid=0 on that edge. With floater=8'h01, fill restarts 5 edges after rst deasserts.
6. In FILL, a level step that commits on the same edge fill_cnt would hit 31 -> no fault, fill_cnt cleared; an invalid code together with level=8 -> FAULT(01), not IDLE.
